// File: rtl/bp_cfg_mmio_responder.sv
// Config-link target: decodes uc_wr/uc_rd into tile config registers or microcode RAM, one io_resp per command.
// Accept-to-resp latency 1 (reg/unmapped), 2 (ucode wr), 3 (ucode rd); io_cmd_ready_o only in READY.
module bp_cfg_mmio_responder
  #(parameter int paddr_width_p         = 40
  , parameter int dword_width_p         = 64
  , parameter int lce_id_width_p        = 4
  , parameter int lce_assoc_p           = 8
  , parameter int cce_id_width_p        = 4
  , parameter int cfg_addr_width_p      = 16
  , parameter int inst_width_p          = 48
  , parameter int inst_ram_addr_width_p = 8
  , parameter int inst_ram_els_p        = 256
  , parameter int npc_width_p           = 39
  , localparam int way_width_lp         = $clog2(lce_assoc_p)
  , localparam int cce_mem_msg_width_lp = 4 + lce_id_width_p + way_width_lp + 3 + paddr_width_p + dword_width_p
  )
  (input  logic                             clk_i
  , input  logic                             reset_n_i
  , input  logic [cce_id_width_p-1:0]        cce_id_i
  , input  logic [cce_mem_msg_width_lp-1:0]  io_cmd_i
  , input  logic                             io_cmd_v_i
  , output logic                             io_cmd_ready_o
  , output logic [cce_mem_msg_width_lp-1:0]  io_resp_o
  , output logic                             io_resp_v_o
  , input  logic                             io_resp_yumi_i
  , output logic                             cfg_reset_o
  , output logic                             cfg_freeze_o
  , output logic [1:0]                       icache_mode_o
  , output logic [1:0]                       dcache_mode_o
  , output logic                             cce_mode_o
  , output logic [npc_width_p-1:0]           npc_o
  , output logic                             npc_w_v_o
  , output logic                             ucode_v_o
  , output logic                             ucode_w_o
  , output logic [inst_ram_addr_width_p-1:0] ucode_addr_o
  , output logic [inst_width_p-1:0]          ucode_data_o
  , input  logic [inst_width_p-1:0]          ucode_data_i
  );

  localparam int nonlocal_width_lp = paddr_width_p - cfg_addr_width_p - 4 - cce_id_width_p;

  typedef enum logic [3:0] {
    e_cce_mem_rd    = 4'h0
    , e_cce_mem_wr    = 4'h1
    , e_cce_mem_uc_rd = 4'h2
    , e_cce_mem_uc_wr = 4'h3
  } bp_cce_mem_cmd_type_e;

  typedef enum logic [1:0] {
    e_lce_mode_uncached = 2'd0
    , e_lce_mode_normal   = 2'd1
    , e_lce_mode_nonspec  = 2'd2
  } bp_lce_mode_e;

  typedef enum logic {
    e_cce_mode_uncached = 1'b0
    , e_cce_mode_normal   = 1'b1
  } bp_cce_mode_e;

  typedef struct packed {
    logic [nonlocal_width_lp-1:0] nonlocal;
    logic [cce_id_width_p-1:0]    cce;
    logic [3:0]                   dev;
    logic [cfg_addr_width_p-1:0]  addr;
  } bp_cfg_addr_s;

  typedef struct packed {
    logic [3:0]                msg_type;
    logic [lce_id_width_p-1:0] lce_id;
    logic [way_width_lp-1:0]   way_id;
    logic [2:0]                size;
    bp_cfg_addr_s              addr;
    logic [dword_width_p-1:0]  data;
  } bp_cce_mem_msg_s;

  localparam logic [3:0]                  cfg_dev_gp       = 4'h2;
  localparam logic [cfg_addr_width_p-1:0] reg_reset_gp     = cfg_addr_width_p'(16'h0001);
  localparam logic [cfg_addr_width_p-1:0] reg_freeze_gp    = cfg_addr_width_p'(16'h0002);
  localparam logic [cfg_addr_width_p-1:0] reg_icache_gp    = cfg_addr_width_p'(16'h0003);
  localparam logic [cfg_addr_width_p-1:0] reg_dcache_gp    = cfg_addr_width_p'(16'h0004);
  localparam logic [cfg_addr_width_p-1:0] reg_cce_mode_gp  = cfg_addr_width_p'(16'h0005);
  localparam logic [cfg_addr_width_p-1:0] reg_npc_gp       = cfg_addr_width_p'(16'h0006);
  localparam logic [cfg_addr_width_p-1:0] ucode_base_gp    = cfg_addr_width_p'(16'h8000);
  localparam logic [cfg_addr_width_p-1:0] ucode_els_lp     = cfg_addr_width_p'(inst_ram_els_p);

  typedef enum logic [1:0] {e_ready, e_ucode_req, e_ucode_wait, e_resp} state_e;

  state_e                      state_r;
  bp_cce_mem_msg_s             cmd, cmd_echo, resp_r;
  logic                        is_wr, is_rd, local_hit, reg_hit, reg_sel, is_ucode;
  logic [cfg_addr_width_p-1:0] ucode_off;
  logic [dword_width_p-1:0]    rd_data;

  assign cmd       = io_cmd_i;
  assign is_wr     = (cmd.msg_type == e_cce_mem_uc_wr);
  assign is_rd     = (cmd.msg_type == e_cce_mem_uc_rd);
  assign local_hit = (is_wr | is_rd) && (cmd.addr.nonlocal == '0)
                     && (cmd.addr.dev == cfg_dev_gp) && (cmd.addr.cce == cce_id_i);
  assign ucode_off = cmd.addr.addr - ucode_base_gp;
  assign is_ucode  = local_hit && (cmd.addr.addr >= ucode_base_gp) && (ucode_off < ucode_els_lp);
  assign reg_sel   = local_hit && reg_hit;

  always_comb begin
    rd_data = '0;
    reg_hit = 1'b1;
    case (cmd.addr.addr)
      reg_reset_gp:    rd_data = dword_width_p'(cfg_reset_o);
      reg_freeze_gp:   rd_data = dword_width_p'(cfg_freeze_o);
      reg_icache_gp:   rd_data = dword_width_p'(icache_mode_o);
      reg_dcache_gp:   rd_data = dword_width_p'(dcache_mode_o);
      reg_cce_mode_gp: rd_data = dword_width_p'(cce_mode_o);
      reg_npc_gp:      rd_data = dword_width_p'(npc_o);
      default:         reg_hit = 1'b0;
    endcase
  end

  // Response header echoes the command; data is only nonzero for a mapped register read.
  always_comb begin
    cmd_echo      = cmd;
    cmd_echo.data = (is_rd && reg_sel) ? rd_data : '0;
  end

  assign io_cmd_ready_o = (state_r == e_ready);
  assign io_resp_o      = resp_r;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_r       <= e_ready;
      resp_r        <= '0;
      io_resp_v_o   <= 1'b0;
      cfg_reset_o   <= 1'b1;
      cfg_freeze_o  <= 1'b1;
      icache_mode_o <= e_lce_mode_uncached;
      dcache_mode_o <= e_lce_mode_uncached;
      cce_mode_o    <= e_cce_mode_uncached;
      npc_o         <= '0;
      npc_w_v_o     <= 1'b0;
      ucode_v_o     <= 1'b0;
      ucode_w_o     <= 1'b0;
      ucode_addr_o  <= '0;
      ucode_data_o  <= '0;
    end else begin
      npc_w_v_o <= 1'b0;
      case (state_r)
        e_ready: if (io_cmd_v_i) begin
          resp_r <= cmd_echo;
          if (is_ucode) begin
            state_r      <= e_ucode_req;
            ucode_v_o    <= 1'b1;
            ucode_w_o    <= is_wr;
            ucode_addr_o <= ucode_off[inst_ram_addr_width_p-1:0];
            ucode_data_o <= cmd.data[inst_width_p-1:0];
          end else begin
            state_r     <= e_resp;
            io_resp_v_o <= 1'b1;
            if (reg_sel && is_wr) begin
              case (cmd.addr.addr)
                reg_reset_gp:    cfg_reset_o   <= cmd.data[0];
                reg_freeze_gp:   cfg_freeze_o  <= cmd.data[0];
                reg_icache_gp:   icache_mode_o <= cmd.data[1:0];
                reg_dcache_gp:   dcache_mode_o <= cmd.data[1:0];
                reg_cce_mode_gp: cce_mode_o    <= cmd.data[0];
                reg_npc_gp: begin
                  npc_o     <= cmd.data[npc_width_p-1:0];
                  npc_w_v_o <= 1'b1;
                end
                default: ;
              endcase
            end
          end
        end
        e_ucode_req: begin
          ucode_v_o <= 1'b0;
          if (ucode_w_o) begin
            state_r     <= e_resp;
            io_resp_v_o <= 1'b1;
          end else begin
            state_r <= e_ucode_wait;
          end
        end
        e_ucode_wait: begin
          resp_r.data <= dword_width_p'(ucode_data_i);
          state_r     <= e_resp;
          io_resp_v_o <= 1'b1;
        end
        e_resp: if (io_resp_yumi_i) begin
          io_resp_v_o <= 1'b0;
          state_r     <= e_ready;
        end
        default: state_r <= e_ready;
      endcase
    end
  end

endmodule

// File: tb/tb_bp_cfg_mmio_responder.sv
// Directed bench for bp_cfg_mmio_responder: expected responses queued at issue, compared on resp_v.
// A small microcode RAM model answers read strobes one cycle later.
module tb_bp_cfg_mmio_responder;

  typedef struct packed {
    logic [3:0]  msg_type;
    logic [3:0]  lce_id;
    logic [2:0]  way_id;
    logic [2:0]  size;
    logic [15:0] nonlocal;
    logic [3:0]  cce;
    logic [3:0]  dev;
    logic [15:0] addr;
    logic [63:0] data;
  } msg_s;

  localparam logic [3:0] UC_RD = 4'h2;
  localparam logic [3:0] UC_WR = 4'h3;
  localparam logic [3:0] MY_CCE = 4'h6;

  logic        clk_i = 1'b0;
  logic        reset_n_i;
  logic [3:0]  cce_id_i;
  msg_s        io_cmd_i;
  logic        io_cmd_v_i;
  logic        io_cmd_ready_o;
  logic [117:0] io_resp_o;
  logic        io_resp_v_o;
  logic        io_resp_yumi_i;
  logic        cfg_reset_o, cfg_freeze_o;
  logic [1:0]  icache_mode_o, dcache_mode_o;
  logic        cce_mode_o;
  logic [38:0] npc_o;
  logic        npc_w_v_o;
  logic        ucode_v_o, ucode_w_o;
  logic [7:0]  ucode_addr_o;
  logic [47:0] ucode_data_o;
  logic [47:0] ucode_data_i;

  bp_cfg_mmio_responder dut (
    .clk_i(clk_i), .reset_n_i(reset_n_i), .cce_id_i(cce_id_i),
    .io_cmd_i(io_cmd_i), .io_cmd_v_i(io_cmd_v_i), .io_cmd_ready_o(io_cmd_ready_o),
    .io_resp_o(io_resp_o), .io_resp_v_o(io_resp_v_o), .io_resp_yumi_i(io_resp_yumi_i),
    .cfg_reset_o(cfg_reset_o), .cfg_freeze_o(cfg_freeze_o),
    .icache_mode_o(icache_mode_o), .dcache_mode_o(dcache_mode_o), .cce_mode_o(cce_mode_o),
    .npc_o(npc_o), .npc_w_v_o(npc_w_v_o),
    .ucode_v_o(ucode_v_o), .ucode_w_o(ucode_w_o), .ucode_addr_o(ucode_addr_o),
    .ucode_data_o(ucode_data_o), .ucode_data_i(ucode_data_i)
  );

  always #5 clk_i = ~clk_i;

  int          vectors = 0;
  int          miscompares = 0;
  msg_s        expq[$];
  int          npc_pulses = 0;
  logic        strobe_w;
  logic [7:0]  strobe_addr;
  logic [47:0] strobe_data;
  logic [47:0] umem [256];
  logic        snap_reset, snap_freeze, snap_npc_w;
  logic [3:0]  lce_ctr = 4'h1;

  always @(posedge clk_i) begin
    if (npc_w_v_o) npc_pulses <= npc_pulses + 1;
    if (ucode_v_o) begin
      strobe_w    <= ucode_w_o;
      strobe_addr <= ucode_addr_o;
      strobe_data <= ucode_data_o;
      if (ucode_w_o) umem[ucode_addr_o] <= ucode_data_o;
      else           ucode_data_i <= umem[ucode_addr_o];
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic msg_s mk(input logic [3:0] t, input logic [3:0] cce, input logic [15:0] a,
                              input logic [63:0] d, input logic [3:0] lce);
    msg_s m;
    m.msg_type = t;   m.lce_id = lce;   m.way_id = 3'h5;  m.size = 3'b011;
    m.nonlocal = '0;  m.cce = cce;      m.dev = 4'h2;     m.addr = a;  m.data = d;
    return m;
  endfunction

  task automatic collect(input string tag);
    msg_s e;
    e = expq.pop_front();
    check({tag, ".resp"}, 128'(io_resp_o), 128'(e));
    io_resp_yumi_i = 1'b1;
    @(posedge clk_i); #1;
    io_resp_yumi_i = 1'b0;
  endtask

  task automatic issue(input string tag, input logic [3:0] t, input logic [3:0] cce,
                       input logic [15:0] a, input logic [63:0] d,
                       input logic [63:0] exp_data, input int lat);
    msg_s m, e;
    int n;
    lce_ctr = lce_ctr + 4'h1;
    m = mk(t, cce, a, d, lce_ctr);
    e = m;
    e.data = exp_data;
    io_cmd_i = m;
    io_cmd_v_i = 1'b1;
    n = 0;
    while (!io_cmd_ready_o && n < 20) begin @(posedge clk_i); #1; n++; end
    check({tag, ".ready"}, 128'(io_cmd_ready_o), 128'(1));
    expq.push_back(e);
    @(posedge clk_i); #1;
    io_cmd_v_i  = 1'b0;
    snap_reset  = cfg_reset_o;
    snap_freeze = cfg_freeze_o;
    snap_npc_w  = npc_w_v_o;
    n = 1;
    while (!io_resp_v_o && n < 10) begin @(posedge clk_i); #1; n++; end
    check({tag, ".lat"}, 128'(n), 128'(lat));
    if (io_resp_v_o) collect(tag);
    else e = expq.pop_front();
  endtask

  initial begin
    msg_s hold_m, hold_e;
    reset_n_i = 1'b0; cce_id_i = MY_CCE; io_cmd_i = '0; io_cmd_v_i = 1'b0;
    io_resp_yumi_i = 1'b0; ucode_data_i = '0;
    repeat (3) @(posedge clk_i);
    #1 reset_n_i = 1'b1;
    @(posedge clk_i); #1;

    check("rst.reset",  128'(cfg_reset_o), 128'(1));
    check("rst.freeze", 128'(cfg_freeze_o), 128'(1));
    check("rst.modes",  128'({icache_mode_o, dcache_mode_o, cce_mode_o}), 128'(0));
    check("rst.npc",    128'(npc_o), 128'(0));
    check("rst.ready",  128'(io_cmd_ready_o), 128'(1));
    check("rst.resp_v", 128'(io_resp_v_o), 128'(0));

    issue("wr_reset", UC_WR, MY_CCE, 16'h0001, 64'h0, 64'h0, 1);
    check("wr_reset.visible", 128'(snap_reset), 128'(0));
    issue("wr_freeze", UC_WR, MY_CCE, 16'h0002, 64'h0, 64'h0, 1);
    check("wr_freeze.visible", 128'(snap_freeze), 128'(0));
    check("wr_freeze.reset_held", 128'(cfg_reset_o), 128'(0));

    issue("wr_npc", UC_WR, MY_CCE, 16'h0006, 64'h0000_0000_7000_0000, 64'h0, 1);
    check("wr_npc.pulse_coincident", 128'(snap_npc_w), 128'(1));
    check("wr_npc.value", 128'(npc_o), 128'(39'h00_7000_0000));
    issue("rd_npc", UC_RD, MY_CCE, 16'h0006, 64'hFFFF, 64'h0000_0000_7000_0000, 1);
    check("npc.pulse_count", 128'(npc_pulses), 128'(1));

    issue("wr_ucode", UC_WR, MY_CCE, 16'h8005, 64'hABC, 64'h0, 2);
    check("wr_ucode.strobe", 128'({strobe_w, strobe_addr, strobe_data}), 128'({1'b1, 8'd5, 48'hABC}));
    issue("rd_ucode", UC_RD, MY_CCE, 16'h8005, 64'h0, 64'hABC, 3);
    check("rd_ucode.strobe", 128'({strobe_w, strobe_addr}), 128'({1'b0, 8'd5}));

    issue("wr_badcce", UC_WR, 4'h9, 16'h0001, 64'h1, 64'h0, 1);
    check("wr_badcce.reset", 128'(cfg_reset_o), 128'(0));
    issue("rd_unmapped", UC_RD, MY_CCE, 16'h0100, 64'h0, 64'h0, 1);
    issue("rd_ucode_end", UC_RD, MY_CCE, 16'h8100, 64'h0, 64'h0, 1);
    issue("rd_ucode_last", UC_RD, MY_CCE, 16'h80FF, 64'h0, 64'h0, 3);
    check("rd_ucode_last.addr", 128'(strobe_addr), 128'(8'hFF));

    issue("wr_dcache", UC_WR, MY_CCE, 16'h0004, 64'hFFFF_FFFF_FFFF_FFFE, 64'h0, 1);
    issue("rd_dcache", UC_RD, MY_CCE, 16'h0004, 64'h0, 64'h2, 1);
    issue("wr_dcache_again", UC_WR, MY_CCE, 16'h0004, 64'h2, 64'h0, 1);
    check("dcache.idempotent", 128'(dcache_mode_o), 128'(2));
    issue("wr_cce_mode", UC_WR, MY_CCE, 16'h0005, 64'h1, 64'h0, 1);
    issue("rd_cce_mode", UC_RD, MY_CCE, 16'h0005, 64'h0, 64'h1, 1);

    // Stall the response with a second command waiting behind it.
    hold_m = mk(UC_WR, MY_CCE, 16'h0003, 64'h1, 4'hC);
    hold_e = hold_m;
    hold_e.data = '0;
    io_cmd_i = hold_m;
    io_cmd_v_i = 1'b1;
    check("hold.ready0", 128'(io_cmd_ready_o), 128'(1));
    @(posedge clk_i); #1;
    io_cmd_i = mk(UC_WR, MY_CCE, 16'h0001, 64'h1, 4'hD);
    for (int i = 0; i < 4; i++) begin
      check("hold.resp_v", 128'(io_resp_v_o), 128'(1));
      check("hold.resp",   128'(io_resp_o), 128'(hold_e));
      check("hold.ready",  128'(io_cmd_ready_o), 128'(0));
      @(posedge clk_i); #1;
    end
    check("hold.icache", 128'(icache_mode_o), 128'(1));
    check("hold.reset_unchanged", 128'(cfg_reset_o), 128'(0));

    reset_n_i = 1'b0;
    #2;
    check("midrst.resp_v", 128'(io_resp_v_o), 128'(0));
    check("midrst.regs", 128'({cfg_reset_o, cfg_freeze_o, icache_mode_o, dcache_mode_o, cce_mode_o}),
          128'({1'b1, 1'b1, 2'd0, 2'd0, 1'b0}));
    check("midrst.npc", 128'(npc_o), 128'(0));
    io_cmd_v_i = 1'b0;
    @(posedge clk_i); #1;
    reset_n_i = 1'b1;
    @(posedge clk_i); #1;
    check("post.ready", 128'(io_cmd_ready_o), 128'(1));
    check("post.resp_v", 128'(io_resp_v_o), 128'(0));
    issue("post_rd_reset", UC_RD, MY_CCE, 16'h0001, 64'h0, 64'h1, 1);
    issue("post_rd_npc", UC_RD, MY_CCE, 16'h0006, 64'h0, 64'h0, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
